sema_bus_arb: RTL



---
 rtl/sema_bus_arb_pkg.sv | 13 +
 rtl/sema_bus_arb_rr_pick.sv | 30 +++
 rtl/sema_bus_arb.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sema_bus_arb_pkg.sv
// Shared types for the semaphore reg-bus arbiter.
// Holds the FSM encoding and the data returned on a timed-out read.
package sema_bus_arb_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_BUSY,
      ARB_TOUT
   } arb_state_e;

   localparam logic [31:0] ARB_TO_RDATA = '0;

endpackage

// File: rtl/sema_bus_arb_rr_pick.sv
// Round-robin priority encoder: first set request at or above ptr,
// wrapping past the top index back to zero.
module sema_bus_arb_rr_pick
   import sema_bus_arb_pkg::*;
#(
   parameter  int unsigned NM = 4,
   localparam int unsigned IW = $clog2(NM)
) (
   input  logic [NM-1:0] req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_vld
);

   logic [IW-1:0] k;

   always_comb begin
      gnt_idx = '0;
      gnt_vld = 1'b0;
      k       = ptr;
      for (int unsigned i = 0; i < NM; i++) begin
         if (!gnt_vld && req[k]) begin
            gnt_idx = k;
            gnt_vld = 1'b1;
         end
         k = (k == IW'(NM - 1)) ? '0 : k + 1'b1;
      end
   end

endmodule

// File: rtl/sema_bus_arb.sv
// Round-robin arbiter merging several reg-bus masters onto the single
// semaphore slave port, with a slave-ack timeout and sticky error flag.
module sema_bus_arb
   import sema_bus_arb_pkg::*;
#(
   parameter  int unsigned NM     = 4,
   parameter  int unsigned DW     = 16,
   parameter  int unsigned AW     = $clog2(DW),
   parameter  int unsigned BW     = $clog2(AW),
   parameter  int unsigned TO_CYC = 16,
   localparam int unsigned IW     = $clog2(NM),
   localparam int unsigned CW     = $clog2(TO_CYC)
) (
   input  logic             mclk,
   input  logic             h_reset_n,
   input  logic [NM-1:0]    m_reg_cs,
   input  logic [NM-1:0]    m_reg_wr,
   input  logic [NM*AW-1:0] m_reg_addr,
   input  logic [NM*DW-1:0] m_reg_wdata,
   input  logic [NM*BW-1:0] m_reg_be,
   output logic [DW-1:0]    m_reg_rdata,
   output logic [NM-1:0]    m_reg_ack,
   output logic             s_reg_cs,
   output logic             s_reg_wr,
   output logic [AW-1:0]    s_reg_addr,
   output logic [DW-1:0]    s_reg_wdata,
   output logic [BW-1:0]    s_reg_be,
   input  logic [DW-1:0]    s_reg_rdata,
   input  logic             s_reg_ack,
   output logic [IW-1:0]    s_gnt_id,
   output logic             to_err,
   input  logic             to_clr
);

   arb_state_e    state_q;
   logic [IW-1:0] rr_ptr_q;
   logic [IW-1:0] gnt_q;
   logic [CW-1:0] cnt_q;
   logic          s_cs_q;
   logic          s_wr_q;
   logic [AW-1:0] s_addr_q;
   logic [DW-1:0] s_wdata_q;
   logic [BW-1:0] s_be_q;
   logic          to_err_q;
   logic          to_err_d;

   logic [AW-1:0] addr_a  [NM];
   logic [DW-1:0] wdata_a [NM];
   logic [BW-1:0] be_a    [NM];

   logic [IW-1:0] pick_idx;
   logic          pick_vld;
   logic [IW-1:0] next_ptr;
   logic          cnt_done;
   logic          ack_ok;
   logic          to_set;

   always_comb begin
      for (int unsigned i = 0; i < NM; i++) begin
         addr_a[i]  = m_reg_addr[i*AW +: AW];
         wdata_a[i] = m_reg_wdata[i*DW +: DW];
         be_a[i]    = m_reg_be[i*BW +: BW];
      end
   end

   sema_bus_arb_rr_pick #(
      .NM      (NM)
   ) u_pick (
      .req     (m_reg_cs),
      .ptr     (rr_ptr_q),
      .gnt_idx (pick_idx),
      .gnt_vld (pick_vld)
   );

   assign next_ptr = (gnt_q == IW'(NM - 1)) ? '0 : gnt_q + 1'b1;
   assign cnt_done = (cnt_q == CW'(TO_CYC - 1));
   assign ack_ok   = (state_q == ARB_BUSY) && s_reg_ack;
   assign to_set   = (state_q == ARB_BUSY) && !s_reg_ack && cnt_done;
   assign to_err_d = to_set | (to_err_q & ~to_clr);

   // Ack and read data are combinational so the master sees them in the
   // same cycle the slave commits its lock update.
   always_comb begin
      m_reg_ack   = '0;
      m_reg_rdata = DW'(ARB_TO_RDATA);
      if (ack_ok) begin
         m_reg_ack[gnt_q] = 1'b1;
         m_reg_rdata      = s_reg_rdata;
      end else if (state_q == ARB_TOUT) begin
         m_reg_ack[gnt_q] = 1'b1;
      end
   end

   always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         state_q   <= ARB_IDLE;
         rr_ptr_q  <= '0;
         gnt_q     <= '0;
         cnt_q     <= '0;
         s_cs_q    <= 1'b0;
         s_wr_q    <= 1'b0;
         s_addr_q  <= '0;
         s_wdata_q <= '0;
         s_be_q    <= '0;
         to_err_q  <= 1'b0;
      end else begin
         to_err_q <= to_err_d;
         unique case (state_q)
            ARB_IDLE: begin
               if (pick_vld) begin
                  s_cs_q    <= 1'b1;
                  s_wr_q    <= m_reg_wr[pick_idx];
                  s_addr_q  <= addr_a[pick_idx];
                  s_wdata_q <= wdata_a[pick_idx];
                  s_be_q    <= be_a[pick_idx];
                  gnt_q     <= pick_idx;
                  cnt_q     <= '0;
                  state_q   <= ARB_BUSY;
               end
            end
            ARB_BUSY: begin
               if (s_reg_ack) begin
                  s_cs_q   <= 1'b0;
                  rr_ptr_q <= next_ptr;
                  state_q  <= ARB_IDLE;
               end else if (cnt_done) begin
                  s_cs_q  <= 1'b0;
                  state_q <= ARB_TOUT;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ARB_TOUT: begin
               rr_ptr_q <= next_ptr;
               state_q  <= ARB_IDLE;
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

   assign s_reg_cs    = s_cs_q;
   assign s_reg_wr    = s_wr_q;
   assign s_reg_addr  = s_addr_q;
   assign s_reg_wdata = s_wdata_q;
   assign s_reg_be    = s_be_q;
   assign s_gnt_id    = gnt_q;
   assign to_err      = to_err_q;

endmodule
